// File: rtl/io_print_rr_arbiter_pkg.sv
// io_print_rr_arbiter_pkg: output FSM state codes and the buffered print entry type.
// With IO_ARB_CORE_TAG_EN defined, every entry also carries the id of the core that sent it.
package io_print_rr_arbiter_pkg;

    localparam logic [0:0] ARB_OUT_IDLE  = 1'b0;
    localparam logic [0:0] ARB_OUT_VALID = 1'b1;

    typedef struct packed {
`ifdef IO_ARB_CORE_TAG_EN
        logic        core_id;
`endif
        logic [31:0] data;
    } print_entry_t;

endpackage

// File: rtl/io_print_fifo.sv
// io_print_fifo: circular print-request buffer with natural pointer wrap and an occupancy count.
// The caller guarantees no push when full and no pop when empty. Entry contents survive reset.
module io_print_fifo
    import io_print_rr_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  print_entry_t           wdata,
    output print_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    print_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/io_print_rr_arbiter.sv
// io_print_rr_arbiter: round-robin merge of two cores' print requests into one buffered display stream.
// Define IO_ARB_CORE_TAG_EN to add print_core_id, which reports the source core of each displayed value.
module io_print_rr_arbiter
    import io_print_rr_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_core0,
    input  logic        req_core1,
    input  logic [31:0] data_core0,
    input  logic [31:0] data_core1,
    output logic        is_ready_core0,
    output logic        is_ready_core1,
    input  logic        print_ready,
    output logic        print_hex_enable,
`ifdef IO_ARB_CORE_TAG_EN
    output logic [31:0] print_output,
    output logic        print_core_id
`else
    output logic [31:0] print_output
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0] count;
    logic          space;
    logic          grant0;
    logic          grant1;
    logic          pop;
    logic          last_grant;
    logic [0:0]    state;
    print_entry_t  wentry;
    print_entry_t  head;
    print_entry_t  out_entry;

    // Space is judged on the registered count only; a same-cycle pop does not free a slot.
    assign space  = !reset && count < CW'(FIFO_DEPTH);
    assign grant0 = space && req_core0 && (!req_core1 || last_grant);
    assign grant1 = space && req_core1 && !grant0;
    assign pop    = count != '0 && (state == ARB_OUT_IDLE || print_ready);

    assign is_ready_core0 = grant0;
    assign is_ready_core1 = grant1;

    always_comb begin
        wentry      = '0;
        wentry.data = grant1 ? data_core1 : data_core0;
`ifdef IO_ARB_CORE_TAG_EN
        wentry.core_id = grant1;
`endif
    end

    io_print_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (grant0 || grant1),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_OUT_IDLE;
            last_grant <= 1'b1;
            out_entry  <= '0;
        end else begin
            if (grant0 || grant1) last_grant <= grant1;
            if (pop) begin
                out_entry <= head;
                state     <= ARB_OUT_VALID;
            end else if (print_ready) begin
                state <= ARB_OUT_IDLE;
            end
        end
    end

    assign print_hex_enable = state == ARB_OUT_VALID;
    assign print_output     = print_hex_enable ? out_entry.data : '0;
`ifdef IO_ARB_CORE_TAG_EN
    assign print_core_id    = print_hex_enable && out_entry.core_id;
`endif

endmodule

// File: tb/tb_io_print_rr_arbiter.sv
// tb_io_print_rr_arbiter: directed and randomized checks of io_print_rr_arbiter against a queue-based model.
// Define IO_ARB_CORE_TAG_EN to also check print_core_id.
module tb_io_print_rr_arbiter;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_core0 = 1'b0;
    logic        req_core1 = 1'b0;
    logic [31:0] data_core0 = '0;
    logic [31:0] data_core1 = '0;
    logic        is_ready_core0;
    logic        is_ready_core1;
    logic        print_ready = 1'b0;
    logic        print_hex_enable;
    logic [31:0] print_output;
`ifdef IO_ARB_CORE_TAG_EN
    logic        print_core_id;
`endif

    always #5 clk = ~clk;

    io_print_rr_arbiter #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_core0        (req_core0),
        .req_core1        (req_core1),
        .data_core0       (data_core0),
        .data_core1       (data_core1),
        .is_ready_core0   (is_ready_core0),
        .is_ready_core1   (is_ready_core1),
        .print_ready      (print_ready),
        .print_hex_enable (print_hex_enable),
`ifdef IO_ARB_CORE_TAG_EN
        .print_output     (print_output),
        .print_core_id    (print_core_id)
`else
        .print_output     (print_output)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: the buffer is a queue, the display is a valid flag plus a held value.
    logic [31:0] mq[$];
    bit          mt[$];
    bit          m_last = 1'b1;
    bit          m_valid = 1'b0;
    logic [31:0] m_out = '0;
    bit          m_id = 1'b0;

    bit          cur_r, cur_pr;
    logic [31:0] cur_a, cur_b;
    bit          e_g0, e_g1, e_en, e_id;
    logic [31:0] e_out;
    logic [CW-1:0] e_cnt;

    task automatic apply(input bit r, input bit q0, input bit q1,
                         input logic [31:0] a, input logic [31:0] b, input bit pr);
        bit full;
        reset = r; req_core0 = q0; req_core1 = q1;
        data_core0 = a; data_core1 = b; print_ready = pr;
        cur_r = r; cur_a = a; cur_b = b; cur_pr = pr;
        full  = mq.size() >= DEPTH;
        e_g0  = !r && q0 && !full && (!q1 || m_last);
        e_g1  = !r && q1 && !full && !e_g0;
        e_en  = m_valid;
        e_out = m_valid ? m_out : 32'h0;
        e_id  = m_valid && m_id;
        e_cnt = CW'(mq.size());
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_r) begin
            mq.delete();
            mt.delete();
            m_last  = 1'b1;
            m_valid = 1'b0;
        end else begin
            if ((!m_valid || cur_pr) && mq.size() > 0) begin
                m_out   = mq.pop_front();
                m_id    = mt.pop_front();
                m_valid = 1'b1;
            end else if (cur_pr) begin
                m_valid = 1'b0;
            end
            if (e_g0) begin mq.push_back(cur_a); mt.push_back(1'b0); m_last = 1'b0; end
            if (e_g1) begin mq.push_back(cur_b); mt.push_back(1'b1); m_last = 1'b1; end
        end
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 1'b1, 1'b1, $urandom, $urandom, 1'b1);
            @(negedge clk);
            nvec++;
            if ({is_ready_core0, is_ready_core1, print_hex_enable, print_output} !== 35'h0 || dut.count !== '0) begin
                nerr++;
                $display("FAIL reset c%0d: ack=%b%b en=%b out=%h cnt=%0d, want all zero", c,
                         is_ready_core0, is_ready_core1, print_hex_enable, print_output, dut.count);
            end
            tick();
        end
    endtask

    task automatic test_single();
        bit p0 = 1'b1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, p0, 1'b0, 32'hAA, 32'h0, 1'b1);
            @(negedge clk);
            nvec++;
            if ({is_ready_core0, is_ready_core1, print_hex_enable, print_output} !== {e_g0, e_g1, e_en, e_out} || dut.count !== e_cnt) begin
                nerr++;
                $display("FAIL single c%0d: ack=%b%b en=%b out=%h cnt=%0d, want ack=%b%b en=%b out=%h cnt=%0d", c,
                         is_ready_core0, is_ready_core1, print_hex_enable, print_output, dut.count, e_g0, e_g1, e_en, e_out, e_cnt);
            end
            nvec++;
            if ((c == 0 && is_ready_core0 !== 1'b1) || (c == 1 && is_ready_core0 !== 1'b0) ||
                (c == 2 && {print_hex_enable, print_output} !== {1'b1, 32'hAA}) ||
                (c == 3 && print_hex_enable !== 1'b0)) begin
                nerr++;
                $display("FAIL single_timing c%0d: ack0=%b en=%b out=%h", c, is_ready_core0, print_hex_enable, print_output);
            end
            if (e_g0) p0 = 1'b0;
            tick();
        end
    endtask

    task automatic test_alternate();
        int ng = 0;
        int no = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            apply(1'b0, 1'b1, 1'b1, 32'h11, 32'h22, 1'b1);
            @(negedge clk);
            nvec++;
            if ({is_ready_core0, is_ready_core1, print_hex_enable, print_output} !== {e_g0, e_g1, e_en, e_out} || dut.count !== e_cnt) begin
                nerr++;
                $display("FAIL alternate c%0d: ack=%b%b en=%b out=%h cnt=%0d, want ack=%b%b en=%b out=%h cnt=%0d", c,
                         is_ready_core0, is_ready_core1, print_hex_enable, print_output, dut.count, e_g0, e_g1, e_en, e_out, e_cnt);
            end
            if (is_ready_core0 || is_ready_core1) begin
                nvec++;
                if ({is_ready_core0, is_ready_core1} !== ((ng % 2 == 0) ? 2'b10 : 2'b01)) begin
                    nerr++;
                    $display("FAIL alternate_grant #%0d: ack=%b%b, want core%0d", ng, is_ready_core0, is_ready_core1, ng % 2);
                end
                ng++;
            end
            if (print_hex_enable) begin
                nvec++;
                if (print_output !== ((no % 2 == 0) ? 32'h11 : 32'h22)) begin
                    nerr++;
                    $display("FAIL alternate_out #%0d: out=%h, want %h", no, print_output, (no % 2 == 0) ? 32'h11 : 32'h22);
                end
                no++;
            end
            tick();
        end
        nvec++;
        if (ng < 12 || no < 10) begin
            nerr++;
            $display("FAIL alternate_rate: grants=%0d outputs=%0d, want >=12 and >=10", ng, no);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] v = 32'h1;
        logic [31:0] want = 32'h1;
        int n_ack = 0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            apply(1'b0, v <= 6, 1'b0, v, 32'h0, c >= 10);
            @(negedge clk);
            nvec++;
            if ({is_ready_core0, is_ready_core1, print_hex_enable, print_output} !== {e_g0, e_g1, e_en, e_out} || dut.count !== e_cnt) begin
                nerr++;
                $display("FAIL backpressure c%0d: ack=%b%b en=%b out=%h cnt=%0d, want ack=%b%b en=%b out=%h cnt=%0d", c,
                         is_ready_core0, is_ready_core1, print_hex_enable, print_output, dut.count, e_g0, e_g1, e_en, e_out, e_cnt);
            end
            if (c < 10 && is_ready_core0) n_ack++;
            if (c >= 2 && c < 10) begin
                nvec++;
                if ({print_hex_enable, print_output} !== {1'b1, 32'h1}) begin
                    nerr++;
                    $display("FAIL backpressure_hold c%0d: en=%b out=%h, want 1 00000001", c, print_hex_enable, print_output);
                end
            end
            if (c >= 10 && print_hex_enable) begin
                nvec++;
                if (print_output !== want) begin
                    nerr++;
                    $display("FAIL backpressure_order: out=%h, want %h", print_output, want);
                end
                want++;
            end
            if (e_g0) v++;
            tick();
        end
        nvec++;
        if (n_ack !== 5 || want !== 32'h7) begin
            nerr++;
            $display("FAIL backpressure_totals: acks_while_stalled=%0d shown_next=%0d, want 5 and 7", n_ack, want);
        end
    endtask

    task automatic test_full_pop();
        bit p0 = 1'b1;
        bit p1 = 1'b0;
        logic [31:0] d0 = 32'h40;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c == 8) p1 = 1'b1;
            apply(1'b0, p0, p1, d0, 32'h77, c >= 8);
            @(negedge clk);
            nvec++;
            if ({is_ready_core0, is_ready_core1, print_hex_enable, print_output} !== {e_g0, e_g1, e_en, e_out} || dut.count !== e_cnt) begin
                nerr++;
                $display("FAIL full_pop c%0d: ack=%b%b en=%b out=%h cnt=%0d, want ack=%b%b en=%b out=%h cnt=%0d", c,
                         is_ready_core0, is_ready_core1, print_hex_enable, print_output, dut.count, e_g0, e_g1, e_en, e_out, e_cnt);
            end
            nvec++;
            if ((c == 8 && ({is_ready_core0, is_ready_core1} !== 2'b00 || dut.count !== CW'(DEPTH))) ||
                (c == 9 && is_ready_core1 !== 1'b1) || dut.count > CW'(DEPTH)) begin
                nerr++;
                $display("FAIL full_pop_edge c%0d: ack=%b%b cnt=%0d", c, is_ready_core0, is_ready_core1, dut.count);
            end
            if (e_g0) begin d0++; p0 = d0 < 32'h48; end
            if (e_g1) p1 = 1'b0;
            tick();
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v = 32'hA1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 7) apply(1'b0, v <= 32'hA4, 1'b0, v, 32'h0, 1'b0);
            else apply(c == 7, c == 7, c == 7, 32'h55, 32'h66, 1'b0);
            @(negedge clk);
            nvec++;
            if ({is_ready_core0, is_ready_core1, print_hex_enable, print_output} !== {e_g0, e_g1, e_en, e_out} || dut.count !== e_cnt) begin
                nerr++;
                $display("FAIL mid_reset c%0d: ack=%b%b en=%b out=%h cnt=%0d, want ack=%b%b en=%b out=%h cnt=%0d", c,
                         is_ready_core0, is_ready_core1, print_hex_enable, print_output, dut.count, e_g0, e_g1, e_en, e_out, e_cnt);
            end
            nvec++;
            if ((c == 6 && {print_hex_enable, print_output, dut.count} !== {1'b1, 32'hA1, CW'(3)}) ||
                (c == 7 && {is_ready_core0, is_ready_core1} !== 2'b00) ||
                (c == 8 && {print_hex_enable, print_output, dut.count} !== {1'b0, 32'h0, CW'(0)})) begin
                nerr++;
                $display("FAIL mid_reset_edge c%0d: ack=%b%b en=%b out=%h cnt=%0d", c,
                         is_ready_core0, is_ready_core1, print_hex_enable, print_output, dut.count);
            end
            if (e_g0) v++;
            tick();
        end
    endtask

`ifdef IO_ARB_CORE_TAG_EN
    task automatic test_core_tag();
        int no = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            apply(1'b0, 1'b1, 1'b1, 32'h11, 32'h22, 1'b1);
            @(negedge clk);
            nvec++;
            if ({print_hex_enable, print_output, print_core_id} !== {e_en, e_out, e_id}) begin
                nerr++;
                $display("FAIL core_tag c%0d: en=%b out=%h id=%b, want en=%b out=%h id=%b", c,
                         print_hex_enable, print_output, print_core_id, e_en, e_out, e_id);
            end
            if (print_hex_enable) begin
                nvec++;
                if (print_core_id !== bit'(no % 2)) begin
                    nerr++;
                    $display("FAIL core_tag_seq #%0d: id=%b, want %0d", no, print_core_id, no % 2);
                end
                no++;
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        bit p0 = 1'b0;
        bit p1 = 1'b0;
        logic [31:0] d0 = '0;
        logic [31:0] d1 = '0;
        bit r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1'b1; d0 = $urandom; end
            if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1'b1; d1 = $urandom; end
            r = $urandom_range(0, 59) == 0;
            apply(r, p0, p1, d0, d1, $urandom_range(0, 2) != 0);
            @(negedge clk);
            nvec++;
            if ({is_ready_core0, is_ready_core1, print_hex_enable, print_output} !== {e_g0, e_g1, e_en, e_out} || dut.count !== e_cnt) begin
                nerr++;
                $display("FAIL random c%0d: ack=%b%b en=%b out=%h cnt=%0d, want ack=%b%b en=%b out=%h cnt=%0d id=%b", c,
                         is_ready_core0, is_ready_core1, print_hex_enable, print_output, dut.count, e_g0, e_g1, e_en, e_out, e_cnt, e_id);
            end
`ifdef IO_ARB_CORE_TAG_EN
            nvec++;
            if (print_core_id !== e_id) begin
                nerr++;
                $display("FAIL random_tag c%0d: id=%b, want %b", c, print_core_id, e_id);
            end
`endif
            if (e_g0) p0 = 1'b0;
            if (e_g1) p1 = 1'b0;
            tick();
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_full_pop();
        test_mid_reset();
`ifdef IO_ARB_CORE_TAG_EN
        test_core_tag();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
